// File: rtl/pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared types and helpers for the pulse sequencer arbiter.
//   seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   DEF_*       : default widths for requester count, period and pulse count
//   slice_of    : extract field idx of width w from a packed per-requester bus
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package pulse_seq_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_CW      = 16;
    localparam int DEF_NW      = 8;

    // Widest packed bus / field the slice helper handles (8 requesters x 32 bits).
    localparam int MAX_BUS_W   = 256;
    localparam int MAX_SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic [MAX_SLICE_W-1:0] slice_of(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_BUS_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = ~({MAX_BUS_W{1'b1}} << w);
        return MAX_SLICE_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches req starting at ptr and
// wrapping, and reports the first set bit.
//   req [NREQ-1:0] : request vector
//   ptr [IW-1:0]   : index with highest priority this round
//   gnt [NREQ-1:0] : one-hot winner (all zero when req is zero)
//   idx [IW-1:0]   : binary index of the winner (0 when req is zero)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rr_arbiter
    import pulse_seq_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/pulse_seq_arbiter.sv
// -----------------------------------------------------------------------------
// pulse_seq_arbiter
// Shares one pulse-train generator among NREQ requesters. The round-robin
// winner's period/count are latched at grant; a burst of count single-cycle
// pulses spaced period cycles apart is emitted on pulse, then done[winner]
// strobes for one cycle.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   req       : per-requester request level
//   period_in : packed periods, field i = [i*CW +: CW] (0 acts as 1)
//   count_in  : packed pulse counts, field i = [i*NW +: NW]
//   abort     : ends the current burst (only honoured in RUN)
//   grant     : one-hot winner, high from grant through the DONE cycle
//   busy      : high while pulses are being generated (RUN)
//   pulse     : shared single-cycle pulse
//   done      : one-cycle completion strobe to the served requester
//   aborted   : coincident with done when the burst was aborted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pulse_seq_arbiter
    import pulse_seq_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW,
    parameter int NW   = DEF_NW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] period_in,
    input  logic [NREQ*NW-1:0] count_in,
    input  logic               abort,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               pulse,
    output logic [NREQ-1:0]    done,
    output logic               aborted
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    seq_state_t      state;
    seq_state_t      state_nxt;

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_gnt;
    logic [NREQ-1:0] grant_q;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   reload;      // max(period,1)-1 of the burst in service
    logic [CW-1:0]   period_sel;
    logic [CW-1:0]   reload_sel;
    logic [NW-1:0]   rem;
    logic [NW-1:0]   count_sel;
    logic            ab_flag;

    logic            any_req;
    logic            run_tick;    // cnt reached zero this RUN cycle
    logic            last_pulse;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign any_req    = |req;
    assign period_sel = CW'(slice_of(MAX_BUS_W'(period_in), 32'(arb_idx), CW));
    assign count_sel  = NW'(slice_of(MAX_BUS_W'(count_in), 32'(arb_idx), NW));
    // Period 0 is folded into period 1 here so the reload value is never -1.
    assign reload_sel = (period_sel == '0) ? '0 : period_sel - 1'b1;
    assign run_tick   = (state == RUN) && (cnt == '0);
    assign last_pulse = run_tick && (rem == NW'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks the last-pulse transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (count_sel == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort || last_pulse) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst counters, latched configuration, winner and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rem     <= '0;
            reload  <= '0;
            ab_flag <= 1'b0;
            winner  <= '0;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner  <= arb_idx;
                        grant_q <= arb_gnt;
                        reload  <= reload_sel;
                        cnt     <= reload_sel;
                        rem     <= count_sel;
                        ab_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        ab_flag <= 1'b1;
                    end else if (run_tick) begin
                        cnt <= reload;
                        rem <= rem - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    // Served requester drops to lowest priority next round.
                    ptr     <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        grant   = grant_q;
        busy    = (state == RUN);
        pulse   = run_tick && !abort;
        done    = (state == DONE) ? grant_q : '0;
        aborted = (state == DONE) && ab_flag;
    end

endmodule

// File: tb/tb_pulse_seq_arbiter.sv
`timescale 1ns/1ps

module tb_pulse_seq_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 16;
    localparam int NW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] period_in;
    logic [NREQ*NW-1:0] count_in;
    logic               abort;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               pulse;
    logic [NREQ-1:0]    done;
    logic               aborted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a burst is described by its start, winner, effective
    // period and end cycle; outputs follow from relative time t in the burst.
    bit m_in  = 1'b0;
    int m_t   = 0;
    int m_end = 0;
    int m_pe  = 1;
    int m_w   = 0;
    int m_ptr = 0;
    bit m_ab  = 1'b0;

    pulse_seq_arbiter #(
        .NREQ (NREQ),
        .CW   (CW),
        .NW   (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .period_in (period_in),
        .count_in  (count_in),
        .abort     (abort),
        .grant     (grant),
        .busy      (busy),
        .pulse     (pulse),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in  = 1'b0;
        m_ptr = 0;
        m_ab  = 1'b0;
        m_t   = 0;
    endtask

    // Advance the model across one rising edge using the inputs of the ending cycle.
    task automatic model_edge();
        int p;
        int c;
        int w;
        bit found;
        if (!rst) begin
            model_reset();
        end else if (!m_in) begin
            if (req != '0) begin
                found = 1'b0;
                w = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        w = (m_ptr + k) % NREQ;
                    end
                end
                p     = int'(period_in[w*CW +: CW]);
                c     = int'(count_in[w*NW +: NW]);
                m_w   = w;
                m_pe  = (p == 0) ? 1 : p;
                m_end = (c == 0) ? 1 : c * m_pe + 1;
                m_t   = 1;
                m_ab  = 1'b0;
                m_in  = 1'b1;
            end
        end else if (m_t == m_end) begin
            m_in  = 1'b0;
            m_ptr = (m_w + 1) % NREQ;
        end else begin
            if (abort) begin
                m_end = m_t + 1;
                m_ab  = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_grant;
        logic [NREQ-1:0] e_done;
        logic            e_busy;
        logic            e_pulse;
        logic            e_ab;
        e_grant = m_in ? NREQ'(1 << m_w) : '0;
        e_busy  = m_in && (m_t < m_end);
        e_pulse = e_busy && ((m_t % m_pe) == 0) && !abort;
        e_done  = (m_in && m_t == m_end) ? NREQ'(1 << m_w) : '0;
        e_ab    = m_in && (m_t == m_end) && m_ab;
        check("grant",   32'(grant),   32'(e_grant));
        check("busy",    32'(busy),    32'(e_busy));
        check("pulse",   32'(pulse),   32'(e_pulse));
        check("done",    32'(done),    32'(e_done));
        check("aborted", 32'(aborted), 32'(e_ab));
    endtask

    // Check the current cycle mid-way, cross the edge, return 1ns after it so
    // the caller can drive inputs for the new cycle.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
        end
    endtask

    task automatic set_cfg(input int i, input int p, input int c);
        period_in[i*CW +: CW] = CW'(p);
        count_in[i*NW +: NW]  = NW'(c);
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        abort     = 1'b0;
        period_in = '0;
        count_in  = '0;
        tick(3);

        // Single requester 0, P=3, C=2.
        rst = 1'b1;
        cyc = 0;
        req = 4'b0001;
        set_cfg(0, 3, 2);
        tick(1);
        req = '0;
        tick(10);

        // All four requesting, P=1, C=1 each.
        for (int i = 0; i < NREQ; i++) set_cfg(i, 1, 1);
        req = 4'b1111;
        tick(18);
        req = '0;
        tick(3);

        // Period 0 behaves as 1; count 0 completes at once.
        set_cfg(2, 0, 4);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(8);
        set_cfg(3, 9, 0);
        req = 4'b1000;
        tick(1);
        req = '0;
        tick(4);

        // P=5, C=10, abort in cycle 12 of the burst.
        set_cfg(1, 5, 10);
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(11);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(4);

        // Config change and req drop mid-burst are ignored.
        set_cfg(0, 2, 3);
        req = 4'b0001;
        tick(3);
        set_cfg(0, 7, 1);
        req = '0;
        tick(10);

        // Asynchronous reset between edges while in RUN.
        set_cfg(2, 4, 5);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        check("rst_grant",   32'(grant),   32'(0));
        check("rst_busy",    32'(busy),    32'(0));
        check("rst_pulse",   32'(pulse),   32'(0));
        check("rst_done",    32'(done),    32'(0));
        check("rst_aborted", 32'(aborted), 32'(0));
        model_reset();
        tick(2);
        rst = 1'b1;
        set_cfg(1, 2, 1);
        set_cfg(2, 2, 1);
        req = 4'b0110;
        tick(1);
        #1;
        check("post_rst_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        tick(6);

        // Randomized traffic, including aborts and reconfiguration in flight.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < NREQ; i++) set_cfg(i, $urandom_range(0, 4), $urandom_range(0, 3));
            end
            abort = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        req   = '0;
        abort = 1'b0;
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
